// File: rtl/audio_pkg.sv
// Shared definitions for the audio sample feeder: sample width, default
// divider for 48 kHz output from a 50 MHz clock, and the feeder state type.
package audio_pkg;

   localparam int SAMPLE_W           = 32;
   localparam int SAMPLE_DIV_DEFAULT = 1042;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } feeder_state_e;

endpackage

// File: rtl/sample_saturator.sv
// Gain stage for the mixed note sum: arithmetic right shift followed by a
// symmetric clamp to a SAT_BITS-wide signed range, sign-extended to 32 bits.
module sample_saturator
   import audio_pkg::*;
#(
   parameter int GAIN_SHIFT = 2,
   parameter int SAT_BITS   = 24
) (
   input  logic [SAMPLE_W-1:0] sample_i,
   output logic [SAMPLE_W-1:0] sample_o,
   output logic                clip_o
);

   // Symmetric limits keep positive and negative full scale equal in magnitude.
   localparam logic signed [SAMPLE_W-1:0] SAT_MAX = (32'sd1 <<< (SAT_BITS - 1)) - 32'sd1;
   localparam logic signed [SAMPLE_W-1:0] SAT_MIN = -SAT_MAX;

   logic signed [SAMPLE_W-1:0] shifted;

   assign shifted = $signed(sample_i) >>> GAIN_SHIFT;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      sample_o = shifted;
      clip_o   = 1'b0;
      if (shifted > SAT_MAX) begin
         sample_o = SAT_MAX;
         clip_o   = 1'b1;
      end else if (shifted < SAT_MIN) begin
         sample_o = SAT_MIN;
         clip_o   = 1'b1;
      end
   end

endmodule

// File: rtl/audio_sample_feeder.sv
// Paces processed audio samples into a stereo codec FIFO at the sample rate,
// holding one sample while the FIFO is full; newer samples replace older ones.
module audio_sample_feeder
   import audio_pkg::*;
#(
   parameter int SAMPLE_DIV = SAMPLE_DIV_DEFAULT,
   parameter int GAIN_SHIFT = 2,
   parameter int SAT_BITS   = 24
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] sample_in,
   input  logic                mute,
   input  logic                write_ready,
   output logic                write,
   output logic [SAMPLE_W-1:0] left_data,
   output logic [SAMPLE_W-1:0] right_data,
   output logic                clip,
   output logic [15:0]         drop_count
);

   localparam int                CNT_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                tick;
   feeder_state_e       state_q, state_d;
   logic [SAMPLE_W-1:0] hold_q, hold_d;
   logic [SAMPLE_W-1:0] data_q, data_d;
   logic                write_q, write_d;
   logic                clip_q, clip_d;
   logic [15:0]         drop_q, drop_d;
   logic [SAMPLE_W-1:0] sat_sample;
   logic [SAMPLE_W-1:0] proc_sample;
   logic                sat_clip;
   logic                do_write;

   sample_saturator #(
      .GAIN_SHIFT (GAIN_SHIFT),
      .SAT_BITS   (SAT_BITS)
   ) u_sat (
      .sample_i (sample_in),
      .sample_o (sat_sample),
      .clip_o   (sat_clip)
   );

   assign proc_sample = mute ? '0 : sat_sample;
   assign tick        = (cnt_q == CNT_LAST);
   assign cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);

   // The write strobe is registered, so a write decided this cycle shows up
   // next cycle; blocking on write_q keeps strobes from landing back to back.
   assign do_write = (state_q == ST_PENDING) && write_ready && !write_q;

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         state_q <= ST_IDLE;
         hold_q  <= '0;
         data_q  <= '0;
         write_q <= 1'b0;
         clip_q  <= 1'b0;
         drop_q  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         state_q <= state_d;
         hold_q  <= hold_d;
         data_q  <= data_d;
         write_q <= write_d;
         clip_q  <= clip_d;
         drop_q  <= drop_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (tick) state_d = ST_PENDING;
         ST_PENDING: if (do_write && !tick) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      write_d = do_write;
      data_d  = do_write ? hold_q : data_q;
      hold_d  = tick ? proc_sample : hold_q;
      clip_d  = tick && sat_clip && !mute;
      drop_d  = drop_q;
      // An unwritten sample replaced by a newer one counts as a drop.
      if ((state_q == ST_PENDING) && tick && !do_write && (drop_q != 16'hFFFF))
         drop_d = drop_q + 16'd1;
   end

   assign write      = write_q;
   assign left_data  = data_q;
   assign right_data = data_q;
   assign clip       = clip_q;
   assign drop_count = drop_q;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Self-checking bench for audio_sample_feeder: directed scenarios plus random
// traffic, all compared every cycle against a queue-based behavioural model.
module tb_audio_sample_feeder;

   localparam int SAMPLE_DIV = 8;
   localparam int GAIN_SHIFT = 2;
   localparam int SAT_BITS   = 24;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] sample_in;
   logic        mute;
   logic        write_ready;
   logic        write;
   logic [31:0] left_data;
   logic [31:0] right_data;
   logic        clip;
   logic [15:0] drop_count;

   audio_sample_feeder #(
      .SAMPLE_DIV (SAMPLE_DIV),
      .GAIN_SHIFT (GAIN_SHIFT),
      .SAT_BITS   (SAT_BITS)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .sample_in   (sample_in),
      .mute        (mute),
      .write_ready (write_ready),
      .write       (write),
      .left_data   (left_data),
      .right_data  (right_data),
      .clip        (clip),
      .drop_count  (drop_count)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          errors = 0;

   // Reference model state: a one-deep mailbox of unwritten samples.
   logic [31:0] m_q[$];
   int          m_cnt;
   int          m_drops;
   bit          m_write;
   logic [31:0] exp_data;
   bit          exp_clip;
   int          cyc;
   bit          saw_clip;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_cnt    = 0;
      m_drops  = 0;
      m_write  = 1'b0;
      exp_data = '0;
      exp_clip = 1'b0;
   endtask

   // Gain and clamp computed with wide integer arithmetic (floor division).
   task automatic model_proc(input logic [31:0] s, input bit m, output logic [31:0] p, output bit c);
      longint v, div, q, lim;
      v   = longint'($signed(s));
      div = longint'(1) << GAIN_SHIFT;
      q   = v / div;
      if ((v < 0) && (v % div != 0)) q = q - 1;
      lim = (longint'(1) << (SAT_BITS - 1)) - 1;
      c   = 1'b0;
      if (q > lim) begin q = lim; c = 1'b1; end
      if (q < -lim) begin q = -lim; c = 1'b1; end
      if (m) begin q = 0; c = 1'b0; end
      p = 32'(q);
   endtask

   // One clock: predict from the current inputs, advance, compare all outputs.
   task automatic step();
      bit          tick;
      bit          do_wr;
      logic [31:0] p;
      bit          pc;
      tick  = (m_cnt == SAMPLE_DIV - 1);
      do_wr = (m_q.size() != 0) && write_ready && !m_write;
      if (do_wr) exp_data = m_q.pop_front();
      exp_clip = 1'b0;
      if (tick) begin
         if (m_q.size() != 0) begin
            m_q.delete();
            if (m_drops != 65535) m_drops++;
         end
         model_proc(sample_in, mute, p, pc);
         m_q.push_back(p);
         exp_clip = pc;
      end
      m_write = do_wr;
      m_cnt   = (m_cnt + 1) % SAMPLE_DIV;
      @(posedge clock);
      #1;
      cyc++;
      if (clip) saw_clip = 1'b1;
      check("write", {31'd0, write}, {31'd0, do_wr});
      check("left_data", left_data, exp_data);
      check("right_data", right_data, exp_data);
      check("clip", {31'd0, clip}, {31'd0, exp_clip});
      check("drop_count", {16'd0, drop_count}, 32'(m_drops));
   endtask

   task automatic run_to_tick();
      while (m_cnt != SAMPLE_DIV - 1) step();
      step();
   endtask

   task automatic wait_write(input string tag, input int bound, output int n);
      bit got;
      got = 1'b0;
      n   = 0;
      while (!got && n < bound) begin
         step();
         n++;
         got = write;
      end
      check({tag, "_write_seen"}, {31'd0, got}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired before the summary line");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int prev;
      int nw;

      reset       = 1'b1;
      sample_in   = 32'd400;
      mute        = 1'b0;
      write_ready = 1'b1;
      cyc         = 0;
      saw_clip    = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      check("rst_write", {31'd0, write}, 32'd0);
      check("rst_left", left_data, 32'd0);
      check("rst_right", right_data, 32'd0);
      check("rst_clip", {31'd0, clip}, 32'd0);
      check("rst_drop", {16'd0, drop_count}, 32'd0);
      reset = 1'b0;

      // Steady flow: one write every SAMPLE_DIV cycles, gain of 1/4.
      prev = 0;
      nw   = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (write) begin
            if (nw > 0) check("032_period", 32'(cyc - prev), 32'(SAMPLE_DIV));
            prev = cyc;
            nw++;
         end
      end
      check("032_write_count", 32'(nw), 32'd4);
      check("032_data", left_data, 32'd100);
      check("032_clip_seen", {31'd0, saw_clip}, 32'd0);
      check("032_drop", {16'd0, drop_count}, 32'd0);

      // Positive and negative saturation.
      sample_in = 32'h7FFF_FFFF;
      run_to_tick();
      check("033_clip_pos", {31'd0, clip}, 32'd1);
      wait_write("033_pos", 4, n);
      check("033_data_pos", left_data, 32'd8388607);
      sample_in = 32'h8000_0000;
      run_to_tick();
      check("033_clip_neg", {31'd0, clip}, 32'd1);
      wait_write("033_neg", 4, n);
      check("033_data_neg", right_data, 32'hFF80_0001);

      // FIFO full across three ticks: only the latest sample survives.
      write_ready = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         sample_in = 32'(4 * k);
         run_to_tick();
      end
      check("034_drop_before", {16'd0, drop_count}, 32'd2);
      write_ready = 1'b1;
      wait_write("034", 4, n);
      check("034_data", left_data, 32'd3);
      check("034_drop", {16'd0, drop_count}, 32'd2);
      nw = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (write) nw++;
      end
      check("034_single_write", 32'(nw), 32'd0);

      // write_ready rises on a tick while a sample is pending.
      write_ready = 1'b0;
      sample_in   = 32'd20;
      run_to_tick();
      sample_in = 32'd40;
      while (m_cnt != SAMPLE_DIV - 1) step();
      write_ready = 1'b1;
      step();
      check("035_old_write", {31'd0, write}, 32'd1);
      check("035_old_data", left_data, 32'd5);
      step();
      check("035_no_back_to_back", {31'd0, write}, 32'd0);
      step();
      check("035_new_write", {31'd0, write}, 32'd1);
      check("035_new_data", left_data, 32'd10);
      check("035_drop", {16'd0, drop_count}, 32'd2);

      // Mute forces zero and hides clipping.
      mute      = 1'b1;
      sample_in = 32'h7FFF_FFFF;
      saw_clip  = 1'b0;
      run_to_tick();
      wait_write("036", 4, n);
      check("036_data", left_data, 32'd0);
      check("036_clip_seen", {31'd0, saw_clip}, 32'd0);
      mute = 1'b0;

      // Random traffic against the model.
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0:       sample_in = $urandom;
            1:       sample_in = 32'($urandom_range(0, 4000)) - 32'd2000;
            2:       sample_in = {$urandom_range(0, 1) != 0 ? 2'b10 : 2'b01, 30'($urandom)};
            default: sample_in = 32'($urandom_range(0, 65535));
         endcase
         mute        = ($urandom_range(0, 9) == 0);
         write_ready = ($urandom_range(0, 2) != 0);
         step();
      end
      mute = 1'b0;

      // Reset while a sample is pending.
      write_ready = 1'b0;
      sample_in   = 32'h0000_0100;
      run_to_tick();
      step();
      reset = 1'b1;
      #1;
      check("037_write", {31'd0, write}, 32'd0);
      check("037_left", left_data, 32'd0);
      check("037_right", right_data, 32'd0);
      check("037_clip", {31'd0, clip}, 32'd0);
      check("037_drop", {16'd0, drop_count}, 32'd0);
      model_reset();
      @(posedge clock);
      #1;
      reset       = 1'b0;
      write_ready = 1'b1;
      wait_write("037_after", 20, n);
      check("037_first_write_step", 32'(n), 32'(SAMPLE_DIV + 1));
      check("037_first_data", left_data, 32'd64);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/audio_sample_feeder.md
AUDIO_SAMPLE_FEEDER -- requirements
Module: audio_sample_feeder

Interface
REQ-001 The block SHALL have parameter SAMPLE_DIV, default 1042, giving clock cycles per output sample (50 MHz / 48 kHz).
REQ-002 The block SHALL have parameter GAIN_SHIFT, default 2, giving the arithmetic right-shift applied to the mixed sum.
REQ-003 The block SHALL have parameter SAT_BITS, default 24, giving the signed width the sample is clipped to.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock, all logic rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port sample_in, input, 32 bits: signed mixed note sum from the wave-control stage, sampled only on tick.
REQ-007 The block SHALL have port mute, input, 1 bit: when 1, the processed sample is forced to 0.
REQ-008 The block SHALL have port write_ready, input, 1 bit: codec FIFO has room for one left/right pair.
REQ-009 The block SHALL have port write, output, 1 bit: one-cycle strobe pushing left_data/right_data.
REQ-010 The block SHALL have ports left_data and right_data, output, 32 bits each: the signed sample sign-extended to 32 bits.
REQ-011 The block SHALL have port clip, output, 1 bit: one-cycle pulse when a captured sample was saturated.
REQ-012 The block SHALL have port drop_count, output, 16 bits: samples overwritten before being written, saturating.

Function
REQ-013 The block SHALL run a tick counter 0..SAMPLE_DIV-1 that asserts tick internally when the count equals SAMPLE_DIV-1 and wraps to 0 on the next cycle.
REQ-014 The block SHALL compute the processed sample by first shifting sample_in right arithmetically by GAIN_SHIFT.
REQ-015 The block SHALL then clamp the shifted value to [-(2^(SAT_BITS-1)-1), +(2^(SAT_BITS-1)-1)], symmetric, and sign-extend it to 32 bits.
REQ-016 mute SHALL override the processed sample to 0 and SHALL suppress clip.
REQ-017 The state machine SHALL have states IDLE and PENDING.
REQ-018 In IDLE on tick, the block SHALL capture the processed sample into the hold register and go to PENDING.
REQ-019 In PENDING with write_ready=1, the block SHALL assert write for exactly one cycle, drive left_data=right_data=hold on that same cycle, and return to IDLE.
REQ-020 In PENDING, write_ready=0 and tick, the block SHALL overwrite hold with the new sample (latest wins), increment drop_count (hold at 16'hFFFF), and stay in PENDING.
REQ-021 In PENDING, write_ready=1 and tick in the same cycle, the block SHALL write the old hold, capture the new sample, stay in PENDING, and SHALL NOT increment drop_count.
REQ-022 Latency SHALL be minimum one cycle, from the tick cycle to the write cycle.
REQ-023 write SHALL never be asserted on two consecutive cycles.
REQ-024 left_data and right_data SHALL hold their last written value between writes.
REQ-025 clip SHALL be registered and SHALL pulse in the cycle after the capturing tick.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 Asserting reset SHALL immediately force state=IDLE, counter=0, hold=0, write=0, left_data=0, right_data=0, clip=0, and drop_count=0.
REQ-028 Reset asserted while in PENDING SHALL discard the pending sample with no write.
REQ-029 The first tick after reset release SHALL occur SAMPLE_DIV cycles after release.

Structure
REQ-030 Shared package audio_pkg SHALL hold SAMPLE_W=32, the default SAMPLE_DIV, and the feeder state enumeration.
REQ-031 Shift and saturate logic SHALL be one combinational sub-module, sample_saturator (in 32, out 32, parameters GAIN_SHIFT and SAT_BITS), instantiated once.

Verification
REQ-032 Bench SAMPLE_DIV=8, write_ready=1, sample_in=32'd400: write pulses every 8 cycles; left_data=right_data=100; clip=0; drop_count=0.
REQ-033 sample_in=32'h7FFF_FFFF: data=32'd8388607; clip pulses. sample_in=32'h8000_0000: data=-8388607 (32'hFF80_0001); clip pulses.
REQ-034 write_ready=0 for 3 ticks with samples 4, 8, 12, then write_ready=1: a single write of data=3; drop_count=2.
REQ-035 write_ready rises exactly on a tick cycle while PENDING: old sample written, new sample written at the next write_ready, drop_count unchanged.
REQ-036 mute=1 with sample_in=32'h7FFF_FFFF: data=0; clip=0.
REQ-037 Reset asserted mid-PENDING: outputs zero asynchronously; no write until SAMPLE_DIV cycles after release.
